muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 54 +++++
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit_div_iter.sv | 53 +++++
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: decoded ALU op codes,
// FSM state encoding, divider iteration count and op-class helpers.
// No logic, no latency, no backpressure.
package muldiv_unit_pkg;

    localparam int ALU_OP_W  = 16;
    localparam int DIV_ITERS = 32;
    localparam int ITER_W    = 6;

    // Decoded (one-hot) ALU operations as produced by the decoder.
    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 16'h0001;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 16'h0002;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 16'h0004;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 16'h0008;
    localparam logic [ALU_OP_W-1:0] ALU_MUL    = 16'h0100;
    localparam logic [ALU_OP_W-1:0] ALU_MULH   = 16'h0200;
    localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 16'h0400;
    localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 16'h0800;
    localparam logic [ALU_OP_W-1:0] ALU_DIV    = 16'h1000;
    localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 16'h2000;
    localparam logic [ALU_OP_W-1:0] ALU_REM    = 16'h4000;
    localparam logic [ALU_OP_W-1:0] ALU_REMU   = 16'h8000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MUL     = 3'd1,
        S_DIV     = 3'd2,
        S_SPECIAL = 3'd3,
        S_FIX     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    function automatic logic is_mul_op(input logic [ALU_OP_W-1:0] op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_m_op(input logic [ALU_OP_W-1:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

    // Signed divide/remainder: operands are treated as two's complement.
    function automatic logic is_sdiv_op(input logic [ALU_OP_W-1:0] op);
        return op inside {ALU_DIV, ALU_REM};
    endfunction

    function automatic logic is_rem_op(input logic [ALU_OP_W-1:0] op);
        return op inside {ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
// Pure wiring, no latency.
// No backpressure: master drives start/aluOp/opA/opB, slave answers busy/stall/done/result.
interface muldiv_unit_if;
    logic                                 start;
    logic [muldiv_unit_pkg::ALU_OP_W-1:0] aluOp;
    logic [31:0]                          opA;
    logic [31:0]                          opB;
    logic                                 busy;
    logic                                 stall;
    logic                                 done;
    logic [31:0]                          result;

    modport master (
        output start, aluOp, opA, opB,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, aluOp, opA, opB,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider core: one quotient bit per cycle, MSB first, on unsigned magnitudes.
// Latency: 32 step cycles after load; last is high during the final step.
// No backpressure: steps only when step is asserted, load wins over step.
// Ports: clk, rst; load/dividend/divisor start a division; step advances one bit;
//        quotient/remainder hold the unsigned result; last flags the 32nd step.
module div_iter
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);

    logic [31:0]       rem_q;
    logic [31:0]       quo_q;   // starts as the dividend, fills with quotient bits from the LSB
    logic [31:0]       dvs_q;
    logic [ITER_W-1:0] cnt_q;
    logic [32:0]       trial;
    logic [32:0]       diff;

    // trial < 2*divisor, so a 33-bit subtract suffices; bit 32 is the borrow.
    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, dvs_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= diff[32] ? trial[31:0] : diff[31:0];
            quo_q <= {quo_q[30:0], ~diff[32]};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == ITER_W'(DIV_ITERS - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit with a single-cycle multiplier and iterative divider.
// Latency from accepting edge to done: multiply/special 2 edges, divide 34 edges.
// No backpressure on results; holds the pipeline via stall and ignores start unless idle.
// Ports: clk, rst (async, active high); bus (slave) carries start/aluOp/opA/opB in and
//        busy/stall/done/result out.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);

    state_t                state_q;
    state_t                state_d;
    logic [ALU_OP_W-1:0]   op_q;
    logic [31:0]           a_q;
    logic [31:0]           b_q;
    logic [31:0]           result_q;

    logic                  accept;
    logic                  special_in;
    logic                  sdiv_in;
    logic [31:0]           a_mag;
    logic [31:0]           b_mag;
    logic                  div_last;
    logic [31:0]           div_quo;
    logic [31:0]           div_rem;

    logic [63:0]           mul_a;
    logic [63:0]           mul_b;
    logic [63:0]           prod;
    logic [31:0]           mul_res;
    logic [31:0]           spec_res;
    logic [31:0]           fix_res;
    logic                  neg_q;
    logic                  neg_r;

    // ---------------- request acceptance ----------------
    assign accept  = bus.start && (state_q == S_IDLE) && is_m_op(bus.aluOp);
    assign sdiv_in = is_sdiv_op(bus.aluOp);

    // Divide by zero and INT_MIN / -1 bypass the iterative divider.
    assign special_in = is_div_op(bus.aluOp) &&
                        ((bus.opB == 32'h0) ||
                         (sdiv_in && bus.opA == 32'h8000_0000 && bus.opB == 32'hFFFF_FFFF));

    // Magnitudes for signed ops; -INT_MIN wraps to 0x80000000, which is the correct magnitude.
    assign a_mag = (sdiv_in && bus.opA[31]) ? -bus.opA : bus.opA;
    assign b_mag = (sdiv_in && bus.opB[31]) ? -bus.opB : bus.opB;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus.busy  = 1'b0;
        bus.stall = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul_op(bus.aluOp)) begin
                        state_d = S_MUL;
                    end else if (special_in) begin
                        state_d = S_SPECIAL;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL, S_SPECIAL, S_FIX: begin
                state_d   = S_DONE;
                bus.busy  = 1'b1;
                bus.stall = 1'b1;
            end
            S_DIV: begin
                if (div_last) begin
                    state_d = S_FIX;
                end
                bus.busy  = 1'b1;
                bus.stall = 1'b1;
            end
            S_DONE: begin
                state_d  = S_IDLE;
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- operand latch ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= bus.aluOp;
            a_q  <= bus.opA;
            b_q  <= bus.opB;
        end
    end

    // ---------------- divider ----------------
    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      (state_q == S_DIV),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    // ---------------- multiply ----------------
    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact
    // for every signedness combination.
    assign mul_a   = {{32{(op_q == ALU_MULH || op_q == ALU_MULHSU) && a_q[31]}}, a_q};
    assign mul_b   = {{32{(op_q == ALU_MULH) && b_q[31]}}, b_q};
    assign prod    = mul_a * mul_b;
    assign mul_res = (op_q == ALU_MUL) ? prod[31:0] : prod[63:32];

    // ---------------- special cases ----------------
    always_comb begin
        spec_res = 32'h0;
        if (b_q == 32'h0) begin
            spec_res = is_rem_op(op_q) ? a_q : 32'hFFFF_FFFF;
        end else begin
            spec_res = is_rem_op(op_q) ? 32'h0 : a_q;
        end
    end

    // ---------------- sign fix-up ----------------
    assign neg_q   = is_sdiv_op(op_q) && (a_q[31] ^ b_q[31]);
    assign neg_r   = is_sdiv_op(op_q) && a_q[31];
    assign fix_res = is_rem_op(op_q) ? (neg_r ? -div_rem : div_rem)
                                     : (neg_q ? -div_quo : div_quo);

    // ---------------- result register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            case (state_q)
                S_MUL:     result_q <= mul_res;
                S_SPECIAL: result_q <= spec_res;
                S_FIX:     result_q <= fix_res;
                default:   result_q <= result_q;
            endcase
        end
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised bench for muldiv_unit with a result scoreboard.
// Checks latency, stall length, done pulse width, reset behaviour and ignored requests.
// Drives on the falling edge and samples outputs on the falling edge.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model written from the RISC-V M-extension definition.
    function automatic logic [31:0] model(input logic [15:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic        [63:0] ua;
        logic        [63:0] ub;
        logic        [63:0] p;
        logic signed [31:0] sq;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        p  = 64'h0;
        sq = 32'sh0;
        case (op)
            ALU_MUL:    begin p = ua * ub; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sq = $signed(a) / $signed(b);
                return sq;
            end
            ALU_REM: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sq = $signed(a) % $signed(b);
                return sq;
            end
            ALU_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: return (b == 32'h0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    // Issue one request, optionally poke start while busy, and check latency,
    // stall length, result, done pulse width and result hold.
    task automatic run_op(input string tag, input logic [15:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit poke_busy);
        int          cyc;
        int          stalls;
        int          exp_lat;
        bit          seen;
        bit          mul;
        bit          special;
        logic [31:0] want;
        mul     = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
        special = !mul && (b == 32'h0 ||
                  (op inside {ALU_DIV, ALU_REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp_lat = (mul || special) ? 2 : 34;

        @(negedge clk);
        bus.start = 1'b1;
        bus.aluOp = op;
        bus.opA   = a;
        bus.opB   = b;
        exp_q.push_back(exp);
        cyc    = 0;
        stalls = 0;
        seen   = 1'b0;
        while (cyc < 60 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) bus.start = 1'b0;
            if (poke_busy && cyc == 5) begin
                bus.start = 1'b1;
                bus.aluOp = ALU_MUL;
                bus.opA   = 32'h5;
                bus.opB   = 32'h6;
            end
            if (poke_busy && cyc == 6) bus.start = 1'b0;
            if (bus.stall) stalls++;
            if (bus.done)  seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat - 1));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_result"}, bus.result, want);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, bus.done}, 32'h0);
        check({tag, "_idle_busy"}, {31'b0, bus.busy}, 32'h0);
        check({tag, "_result_held"}, bus.result, want);
        last_res = want;
    endtask

    logic [15:0] ops [8];
    logic [15:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        ops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.aluOp = '0;
        bus.opA   = '0;
        bus.opB   = '0;
        last_res  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",   {31'b0, bus.busy},  32'h0);
        check("rst_stall",  {31'b0, bus.stall}, 32'h0);
        check("rst_done",   {31'b0, bus.done},  32'h0);
        check("rst_result", bus.result,         32'h0);
        rst = 1'b0;

        // Multiplies
        run_op("mul_7_m3",    ALU_MUL,    32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulhu_max",   ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulh_intmin", ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhsu_m1",   ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Divides, the first one also pokes start while busy
        run_op("div_m20_3",   ALU_DIV,  32'hFFFF_FFEC, 32'h3, 32'hFFFF_FFFA, 1'b1);
        run_op("rem_m20_3",   ALU_REM,  32'hFFFF_FFEC, 32'h3, 32'hFFFF_FFFE, 1'b0);
        run_op("rem_20_m3",   ALU_REM,  32'd20, 32'hFFFF_FFFD, 32'h2, 1'b0);
        run_op("divu_max_1",  ALU_DIVU, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 1'b0);

        // Special cases
        run_op("divu_100_0",  ALU_DIVU, 32'd100, 32'h0, 32'hFFFF_FFFF, 1'b0);
        run_op("remu_100_0",  ALU_REMU, 32'd100, 32'h0, 32'h0000_0064, 1'b0);
        run_op("div_ovf",     ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("rem_ovf",     ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_op("rem_m7_0",    ALU_REM,  32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 1'b0);

        // Start with a non-M op is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluOp = ALU_ADD;
        bus.opA   = 32'h1234;
        bus.opB   = 32'h1;
        @(negedge clk);
        check("add_busy",   {31'b0, bus.busy}, 32'h0);
        check("add_result", bus.result, last_res);
        bus.start = 1'b0;
        @(negedge clk);
        check("add_busy2",  {31'b0, bus.busy}, 32'h0);
        check("add_done",   {31'b0, bus.done}, 32'h0);

        // Reset in the middle of a divide
        bus.start = 1'b1;
        bus.aluOp = ALU_DIV;
        bus.opA   = 32'd1000;
        bus.opB   = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {31'b0, bus.busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy",   {31'b0, bus.busy},  32'h0);
        check("abort_stall",  {31'b0, bus.stall}, 32'h0);
        check("abort_done",   {31'b0, bus.done},  32'h0);
        check("abort_result", bus.result,         32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op("divu_9_2", ALU_DIVU, 32'd9, 32'd2, 32'h4, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            rop = ops[$urandom_range(0, 7)];
            ra  = $urandom();
            rb  = (i == 3) ? 32'h0 : ($urandom() >> $urandom_range(0, 31));
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
